// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice built from two halfadder cells iterates LSB-first over WIDTH bits.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic load;
  logic step;
  logic last;
  logic busy_d;
  logic done_d;

  logic s0, c0, s1, c1, carry_next;

  halfadder ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(s0), .c(c0));
  halfadder ha1 (.a(s0),      .b(carry),   .s(s1), .c(c1));

  assign carry_next = c0 | c1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_SHIFT;
      S_SHIFT: if (cnt == LAST) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    load   = (state == S_IDLE) && start;
    step   = (state == S_SHIFT);
    last   = step && (cnt == LAST);
    busy_d = (state == S_SHIFT);
    done_d = (state == S_DONE);
  end

  // busy/done are registered copies of the state, so they trail it by one cycle
  // and the result registers update on the same edge that raises done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (step) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        res   <= {s1, res[WIDTH-1:1]};
        carry <= carry_next;
        cnt   <= cnt + CNT_W'(1);
      end
      if (done_d) begin
        sum  <= res;
        cout <= carry;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_int <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (last) ovf_int <= carry ^ carry_next;
      if (done_d) ovf <= ovf_int;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); ovf checks run when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int compared = 0;
  int mismatched = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Launches one job (start high for one edge) and observes W+14 cycles after the start edge.
  // Optionally re-pulses start with a=b=1 at cycle 3 to exercise the ignore path.
  task automatic do_job(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic repulse, output int lat, output int ndone,
                        output int first_busy, output int nbusy, output int bad);
    logic [W-1:0] prev;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev = sum;
    lat = -1; ndone = 0; first_busy = -1; nbusy = 0; bad = 0;
    for (int n = 1; n <= W + 14; n++) begin
      @(posedge clk); #1;
      if (busy && done) bad++;
      if (busy && sum !== prev) bad++;
      if (busy) begin
        nbusy++;
        if (first_busy < 0) first_busy = n;
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (!busy) prev = sum;
      if (repulse && n == 3) begin a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1; end
      if (repulse && n == 4) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({busy, done, sum, cout} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    compared++;
    if (ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, nd, fb, nb, bad;
    do_job(8'h12, 8'h34, 1'b0, 1'b0, lat, nd, fb, nb, bad);
    compared++;
    if (sum !== 8'h46 || cout !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_sum: got %h/%b want 46/0", sum, cout);
    end
    compared++;
    if (lat !== 9 || nd !== 1) begin
      mismatched++;
      $display("FAIL basic_done_timing: got latency %0d count %0d want 9 and 1", lat, nd);
    end
    compared++;
    if (fb !== 1 || nb !== W || bad !== 0) begin
      mismatched++;
      $display("FAIL basic_busy: got first %0d count %0d bad %0d want 1 %0d 0", fb, nb, bad, W);
    end
  endtask

  task automatic test_carry();
    int lat, nd, fb, nb, bad;
    do_job(8'hFF, 8'h01, 1'b0, 1'b0, lat, nd, fb, nb, bad);
    compared++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      mismatched++;
      $display("FAIL carry_ff_01: got %h/%b want 00/1", sum, cout);
    end
    do_job(8'hFF, 8'hFF, 1'b1, 1'b0, lat, nd, fb, nb, bad);
    compared++;
    if (sum !== 8'hFF || cout !== 1'b1) begin
      mismatched++;
      $display("FAIL carry_ff_ff_1: got %h/%b want ff/1", sum, cout);
    end
    do_job(8'hA5, 8'h5A, 1'b1, 1'b0, lat, nd, fb, nb, bad);
    compared++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      mismatched++;
      $display("FAIL carry_a5_5a_1: got %h/%b want 00/1", sum, cout);
    end
  endtask

  task automatic test_start_ignored();
    int lat, nd, fb, nb, bad;
    do_job(8'h0F, 8'h01, 1'b0, 1'b1, lat, nd, fb, nb, bad);
    compared++;
    if (sum !== 8'h10 || cout !== 1'b0) begin
      mismatched++;
      $display("FAIL ignore_result: got %h/%b want 10/0", sum, cout);
    end
    compared++;
    if (nd !== 1 || lat !== 9) begin
      mismatched++;
      $display("FAIL ignore_done_count: got %0d at %0d want 1 at 9", nd, lat);
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL ignore_sum_stable: got %0d violations want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2, nd, bad;
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n1 = -1; n2 = -1; nd = 0; bad = 0;
    for (int n = 1; n <= 2 * W + 10; n++) begin
      @(posedge clk); #1;
      if (busy && done) bad++;
      if (done) begin
        nd++;
        if (n1 < 0) begin
          n1 = n;
          compared++;
          if (sum !== 8'h4C || cout !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_first: got %h/%b want 4c/0", sum, cout);
          end
          a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        end else if (n2 < 0) n2 = n;
      end else start = 1'b0;
    end
    start = 1'b0;
    compared++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_second: got %h/%b want 00/1", sum, cout);
    end
    compared++;
    if (nd !== 2 || n2 - n1 !== W + 2 || bad !== 0) begin
      mismatched++;
      $display("FAIL b2b_timing: got dones %0d spacing %0d overlap %0d want 2 %0d 0", nd, n2 - n1, bad, W + 2);
    end
`ifdef SERIAL_ADDER_OVF_EN
    compared++;
    if (ovf !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ovf_80_80: got %b want 1", ovf);
    end
`endif
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int lat, nd, fb, nb, bad;
    do_job(8'h7F, 8'h01, 1'b0, 1'b0, lat, nd, fb, nb, bad);
    compared++;
    if (ovf !== 1'b1 || sum !== 8'h80) begin
      mismatched++;
      $display("FAIL ovf_7f_01: got ovf=%b sum=%h want 1/80", ovf, sum);
    end
    do_job(8'hFF, 8'h01, 1'b0, 1'b0, lat, nd, fb, nb, bad);
    compared++;
    if (ovf !== 1'b0 || sum !== 8'h00) begin
      mismatched++;
      $display("FAIL ovf_ff_01: got ovf=%b sum=%h want 0/00", ovf, sum);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int nd;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compared++;
    if ({busy, done, sum, cout} !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    nd = 0;
    for (int n = 0; n < W + 6; n++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    compared++;
    if (nd !== 0 || sum !== 8'h00) begin
      mismatched++;
      $display("FAIL midreset_no_done: got %0d active cycles sum=%h want 0/00", nd, sum);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
